// File: rtl/fre_calc_pkg.sv
// rtl/fre_calc_pkg.sv - shared widths, reference clock and FSM encoding for the frequency calculator
package fre_calc_pkg;

    localparam int FC_CNT_WIDTH = 32;
    localparam int FC_CLK_FRE   = 200000000;
    localparam int FC_NUM_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } fc_state_e;

endpackage

// File: rtl/seq_udiv.sv
// rtl/seq_udiv.sv - generic unsigned restoring divider, one quotient bit per clock, MSB first
module seq_udiv #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_or,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    // num_q shifts dividend bits out at the top and quotient bits in at the bottom
    logic [WIDTH-1:0] num_q;
    logic [WIDTH-1:0] rem_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             ge;

    always_comb begin
        rem_sh  = {rem_q, num_q[WIDTH-1]};
        ge      = (rem_sh >= {1'b0, divisor});
        // the true difference is below divisor, so the low WIDTH bits are exact
        rem_sub = rem_sh[WIDTH-1:0] - divisor;
    end

    always_ff @(posedge clk or posedge rst_or) begin
        if (rst_or) begin
            num_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            num_q <= dividend;
            rem_q <= '0;
            cnt_q <= CW'(WIDTH - 1);
            run_q <= 1'b1;
        end else if (run_q) begin
            rem_q <= ge ? rem_sub : rem_sh[WIDTH-1:0];
            num_q <= {num_q[WIDTH-2:0], ge};
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign quotient = num_q;
    assign done     = run_q && (cnt_q == '0);

endmodule

// File: rtl/fre_calc.sv
// rtl/fre_calc.sv - rounded frequency = sig_cnt * CLK_FRE / gate_cnt with saturation and status flags
module fre_calc
    import fre_calc_pkg::*;
#(
    parameter int CNT_WIDTH = FC_CNT_WIDTH,
    parameter int CLK_FRE   = FC_CLK_FRE,
    parameter int NUM_WIDTH = FC_NUM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_or,
    input  logic [CNT_WIDTH-1:0] sig_cnt,
    input  logic [CNT_WIDTH-1:0] gate_cnt,
    input  logic                 cnt_valid,
    output logic [CNT_WIDTH-1:0] fre_out,
    output logic                 fre_valid,
    output logic                 busy,
    output logic                 sat,
    output logic                 div_zero,
    output logic                 overrun
);

    fc_state_e            state_q;
    logic                 cnt_valid_d;
    logic [CNT_WIDTH-1:0] sig_q;
    logic [CNT_WIDTH-1:0] gate_q;

    logic                 start;
    logic                 div_start;
    logic                 div_done;
    logic [NUM_WIDTH-1:0] numerator;
    logic [NUM_WIDTH-1:0] quotient;

    assign start     = cnt_valid & ~cnt_valid_d;
    assign div_start = (state_q == ST_LOAD);

    // adding half the divisor turns the truncating divide into round-half-up
    assign numerator = NUM_WIDTH'(sig_q) * NUM_WIDTH'(CLK_FRE) + NUM_WIDTH'(gate_q >> 1);

    seq_udiv #(
        .WIDTH (NUM_WIDTH)
    ) u_div (
        .clk      (clk),
        .rst_or   (rst_or),
        .start    (div_start),
        .dividend (numerator),
        .divisor  (NUM_WIDTH'(gate_q)),
        .quotient (quotient),
        .done     (div_done)
    );

    always_ff @(posedge clk or posedge rst_or) begin
        if (rst_or) begin
            cnt_valid_d <= 1'b0;
        end else begin
            cnt_valid_d <= cnt_valid;
        end
    end

    always_ff @(posedge clk or posedge rst_or) begin
        if (rst_or) begin
            state_q   <= ST_IDLE;
            sig_q     <= '0;
            gate_q    <= '0;
            fre_out   <= '0;
            fre_valid <= 1'b0;
            busy      <= 1'b0;
            sat       <= 1'b0;
            div_zero  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            fre_valid <= 1'b0;
            // any start outside IDLE, including the DONE cycle, is dropped
            if (start && (state_q != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sig_q   <= sig_cnt;
                        gate_q  <= gate_cnt;
                        busy    <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_DIV;
                end
                ST_DIV: begin
                    if (div_done) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    fre_valid <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= ST_IDLE;
                    if (gate_q == '0) begin
                        fre_out  <= '1;
                        div_zero <= 1'b1;
                        sat      <= 1'b0;
                    end else if (quotient[NUM_WIDTH-1:CNT_WIDTH] != '0) begin
                        fre_out  <= '1;
                        sat      <= 1'b1;
                        div_zero <= 1'b0;
                    end else begin
                        fre_out  <= quotient[CNT_WIDTH-1:0];
                        sat      <= 1'b0;
                        div_zero <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
